// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file for the IcyRisc core.
//   Entry 0 is hard-wired to zero.
//   Entry SP_IDX resets to SP_INIT; every other entry resets to 0.
//   Reads pass through a pipeline that is RD_LAT (1 or 2) stages deep.
//   Write ports have fixed priority: the highest-numbered port wins.
//
// Ports:
//   clk      - clock; all state updates on posedge
//   rst      - asynchronous active-high reset
//   stall    - holds the read pipeline; writes still commit
//   rd_addr  - NRD read addresses, port p at [p*AW +: AW]
//   rd_data  - NRD read results, port p at [p*XLEN +: XLEN]
//   wr_en    - NWR write enables
//   wr_addr  - NWR write addresses, port k at [k*AW +: AW]
//   wr_data  - NWR write data, port k at [k*XLEN +: XLEN]
//
// Build option REGFILE_BYPASS_EN:
//   Defined   - a same-edge write is forwarded into stage 1.
//   Undefined - stage 1 reads the entry value from before the write.
module regfile_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 1,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned SP_IDX  = 2,
  parameter logic [31:0] SP_INIT = 32'h400,
  localparam int unsigned AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data
);

  // Storage is rounded up to a power of two so that any address indexes safely.
  // Entries at or above NREGS are never written and never read.
  localparam int unsigned DEPTH = 1 << AW;

  logic [XLEN-1:0]     regs_q [DEPTH];
  logic [NRD*XLEN-1:0] rd_val_c;
  logic [NRD*XLEN-1:0] s1_q;

  // An address is writable or readable only if it is nonzero and below NREGS.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ((AW+1)'(a) < (AW+1)'(NREGS));
  endfunction

  // Register array update.
  // Port order gives priority: later ports overwrite earlier ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
      end
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wr_en[k] && addr_ok(wr_addr[k*AW +: AW])) begin
          regs_q[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Value captured into stage 1 for each read port.
  always_comb begin
    rd_val_c = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (addr_ok(rd_addr[p*AW +: AW])) begin
        rd_val_c[p*XLEN +: XLEN] = regs_q[rd_addr[p*AW +: AW]];
      end
`ifdef REGFILE_BYPASS_EN
      // Forward same-edge writes; the highest matching port wins.
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wr_en[k] && addr_ok(wr_addr[k*AW +: AW]) &&
            (wr_addr[k*AW +: AW] == rd_addr[p*AW +: AW])) begin
          rd_val_c[p*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
        end
      end
`endif
    end
  end

  // Read stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else if (!stall) begin
      s1_q <= rd_val_c;
    end
  end

  // Optional read stage 2, selected by RD_LAT.
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [NRD*XLEN-1:0] s2_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_q <= '0;
        end else if (!stall) begin
          s2_q <= s1_q;
        end
      end

      assign rd_data = s2_q;
    end else begin : g_lat1
      assign rd_data = s1_q;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp.
// Configuration: NREGS=24, NRD=2, NWR=2, RD_LAT=2.
// Each read is pushed to a scoreboard when it is sampled.
// It is popped and compared when it reaches rd_data.
module tb_regfile_mp;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 24;
  localparam int unsigned AW     = 5;
  localparam int unsigned NRD    = 2;
  localparam int unsigned NWR    = 2;
  localparam int unsigned RD_LAT = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                stall;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .RD_LAT(RD_LAT),
    .SP_IDX(2), .SP_INIT(32'h400)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;

  exp_t        sb[$];
  exp_t        held;
  logic [31:0] mem [32];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ok(input logic [4:0] a);
    return (a != 5'd0) && (32'(a) < NREGS);
  endfunction

  // Reference result for a read sampled at the coming edge.
  function automatic logic [31:0] model_rd(input logic [4:0] a,
      input logic w0, input logic [4:0] a0, input logic [31:0] d0,
      input logic w1, input logic [4:0] a1, input logic [31:0] d1);
    logic [31:0] v;
    v = ok(a) ? mem[a] : 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (w0 && ok(a0) && a0 == a) v = d0;
    if (w1 && ok(a1) && a1 == a) v = d1;
`else
    if (w0 && w1 && a0 == a1 && d0 == d1) v = v;
`endif
    return v;
  endfunction

  // Clears the reference state and the scoreboard to match a freshly reset DUT.
  task automatic model_reset();
    exp_t z;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[2] = 32'h400;
    sb.delete();
    z.tag = "post_reset"; z.e0 = 32'h0; z.e1 = 32'h0;
    for (int i = 0; i < int'(RD_LAT) - 1; i++) sb.push_back(z);
    held = z;
  endtask

  // One clock cycle, entered and left at the negedge.
  task automatic step(input string tag, input logic st,
      input logic [4:0] ra0, input logic [4:0] ra1,
      input logic w0, input logic [4:0] a0, input logic [31:0] d0,
      input logic w1, input logic [4:0] a1, input logic [31:0] d1);
    exp_t e;
    stall   = st;
    rd_addr = {ra1, ra0};
    wr_en   = {w1, w0};
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
    if (!st) begin
      e.tag = tag;
      e.e0  = model_rd(ra0, w0, a0, d0, w1, a1, d1);
      e.e1  = model_rd(ra1, w0, a0, d0, w1, a1, d1);
      sb.push_back(e);
    end
    if (w0 && ok(a0)) mem[a0] = d0;
    if (w1 && ok(a1)) mem[a1] = d1;
    @(posedge clk);
    #1;
    if (!st) held = sb.pop_front();
    check({held.tag, ".p0"}, rd_data[0 +: 32], held.e0);
    check({held.tag, ".p1"}, rd_data[32 +: 32], held.e1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rd_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    #1;
    check("reset_state.p0", rd_data[0 +: 32], 32'h0);
    check("reset_state.p1", rd_data[32 +: 32], 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // SP reset value and a plain cleared entry.
    step("sp_and_r5", 1'b0, 5'd2, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // x0 protection on both write ports.
    step("x0_write", 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hDEADBEEF);
    step("x0_read", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Latency: write r7, wait, read r7 and SP.
    step("w7", 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'h0);
    idle(1);
    step("r7_sp", 1'b0, 5'd7, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Collision: port 1 wins.
    step("collide9", 1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd9, 32'hBBBB);
    step("r9", 1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Out-of-range write is dropped; the last valid entry works.
    step("w23_w30", 1'b0, 5'd0, 5'd0, 1'b1, 5'd23, 32'h2323, 1'b1, 5'd30, 32'h99);
    step("r30_r23", 1'b0, 5'd30, 5'd23, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Same-edge read and write of r3.
    step("rw3_same", 1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0);
    step("r3_after", 1'b0, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Stall: an in-flight SP read, with a write to SP committed while stalled.
    step("r2_prestall", 1'b0, 5'd2, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step("stall_w2", 1'b1, 5'd7, 5'd9, 1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 32'h0);
    step("stall_b", 1'b1, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step("stall_c", 1'b1, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step("r2_poststall", 1'b0, 5'd2, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    idle(2);

    // Mid-run reset: reads in flight, then an asynchronous clear.
    step("r7_r9_a", 1'b0, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step("r7_r9_b", 1'b0, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst.p0", rd_data[0 +: 32], 32'h0);
    check("async_rst.p1", rd_data[32 +: 32], 32'h0);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hFFFF};
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_en = '0;
    model_reset();
    step("rst_sp_r5", 1'b0, 5'd2, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step("rst_r7_r9", 1'b0, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
